// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared CPU package: control-unit opcodes plus the encodings used by the
// single-port memory arbiter (FSM state codes and read-owner codes).
// No ports; imported with `import mem_port_arbiter_pkg::*;`.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Control-unit opcodes.
  typedef enum logic [3:0] {
    OPC_NOP    = 4'd0,
    OPC_LOAD   = 4'd1,
    OPC_STORE  = 4'd2,
    OPC_ALU    = 4'd3,
    OPC_ALUI   = 4'd4,
    OPC_BRANCH = 4'd5,
    OPC_JUMP   = 4'd6
  } ctrl_opcode_e;

  // Opcodes that need the data side of the memory port.
  function automatic logic is_mem_opcode(input ctrl_opcode_e op);
    return (op == OPC_LOAD) || (op == OPC_STORE);
  endfunction

  // Arbiter FSM states. Kept as plain constants so older code comparing
  // against a raw bit still works.
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Who owns the read data returning next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DS   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, data requester, shared read data, lock status
// and memory-side signals of the memory port arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            rvalids, rdata, locked and the memory command)
//   master : environment view (requesters plus memory model)
// Parameters: ADDR_W address width, DATA_W data width.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  // fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  // data side
  logic              ds_req;
  logic              ds_we;
  logic              ds_lock;
  logic [ADDR_W-1:0] ds_addr;
  logic [DATA_W-1:0] ds_wdata;
  logic              ds_gnt;
  logic              ds_rvalid;
  // shared read data and lock status
  logic [DATA_W-1:0] rdata;
  logic              locked;
  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ds_req, ds_we, ds_lock, ds_addr, ds_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, ds_gnt, ds_rvalid, rdata, locked,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ds_req, ds_we, ds_lock, ds_addr, ds_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, ds_gnt, ds_rvalid, rdata, locked,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between an instruction fetch
// requester (read only) and a data requester (load/store, optional lock).
// Grants are combinational; the data side wins ties unless the fetch side
// has been denied MAX_WAIT cycles in a row. A locked data access keeps the
// port for the data side (LOCK state) until an unlocked transfer or an idle
// data cycle. Read ownership is registered so the one-cycle-late memory data
// is flagged to the correct requester.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (requests, grants, rvalids,
//                rdata, locked, memory command and mem_rdata)
// Parameters: ADDR_W, DATA_W, MAX_WAIT (1..7).
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  // MAX_WAIT is at most 7, so a 3-bit counter always holds it.
  localparam int              CNT_W    = 3;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  owner_e           owner_p1, owner_nxt;
  logic             force_if;
  logic             if_gnt, ds_gnt;

  // Forced fetch grant only in ARB; a starved fetch waits out a LOCK.
  assign force_if = (state == ST_ARB) && (starve_cnt == WAIT_MAX);

  always_comb begin
    if_gnt = 1'b0;
    ds_gnt = 1'b0;
    if (state == ST_LOCK) begin
      ds_gnt = bus.ds_req;
    end else if (bus.if_req && (!bus.ds_req || force_if)) begin
      if_gnt = 1'b1;
    end else begin
      ds_gnt = bus.ds_req;
    end
  end

  assign bus.if_gnt = if_gnt;
  assign bus.ds_gnt = ds_gnt;

  // Memory command follows the winner; everything is 0 with no grant.
  always_comb begin
    bus.mem_en    = if_gnt | ds_gnt;
    bus.mem_we    = ds_gnt & bus.ds_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (if_gnt) begin
      bus.mem_addr = bus.if_addr;
    end else if (ds_gnt) begin
      bus.mem_addr = bus.ds_addr;
      if (bus.ds_we) begin
        bus.mem_wdata = bus.ds_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_ARB) begin
      if (ds_gnt && bus.ds_lock) begin
        state_nxt = ST_LOCK;
      end
    end else begin
      // In LOCK ds_gnt == ds_req, so this covers both exit conditions.
      if (!bus.ds_req || !bus.ds_lock) begin
        state_nxt = ST_ARB;
      end
    end
  end

  // Counts consecutive fetch denials, saturating at MAX_WAIT.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!bus.if_req || if_gnt) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != WAIT_MAX) begin
      starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (if_gnt) begin
      owner_nxt = OWN_IF;
    end else if (ds_gnt && !bus.ds_we) begin
      owner_nxt = OWN_DS;
    end
  end

  // ---- stage p0 -> p1: state, starvation count, read owner ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ARB;
      starve_cnt <= '0;
      owner_p1   <= OWN_NONE;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      owner_p1   <= owner_nxt;
    end
  end

  assign bus.if_rvalid = (owner_p1 == OWN_IF);
  assign bus.ds_rvalid = (owner_p1 == OWN_DS);
  assign bus.rdata     = bus.mem_rdata;
  assign bus.locked    = (state == ST_LOCK);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  mem_port_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous single-port memory model: mem[i] = 0x57 + i after reset.
  logic [7:0] mem [16];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h57 + i);
      bus.mem_rdata <= 8'h00;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct packed {
    logic       ir; logic [3:0] ia;
    logic       dr; logic dw; logic dl; logic [3:0] da; logic [7:0] dwd;
    logic       e_ig; logic e_dg; logic e_en; logic e_we;
    logic [3:0] e_ma; logic [7:0] e_wd; logic e_lk;
    logic       e_irv; logic e_drv; logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic add(input logic ir, input logic [3:0] ia,
                     input logic dr, input logic dw, input logic dl,
                     input logic [3:0] da, input logic [7:0] dwd,
                     input logic ig, input logic dg, input logic en, input logic we,
                     input logic [3:0] ma, input logic [7:0] wd, input logic lk,
                     input logic irv, input logic drv, input logic [7:0] rd);
    vec_t v;
    v = '{ir, ia, dr, dw, dl, da, dwd, ig, dg, en, we, ma, wd, lk, irv, drv, rd};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [3:0] ia, input logic dr,
                       input logic dw, input logic dl, input logic [3:0] da,
                       input logic [7:0] dwd);
    bus.if_req = ir; bus.if_addr = ia;
    bus.ds_req = dr; bus.ds_we = dw; bus.ds_lock = dl;
    bus.ds_addr = da; bus.ds_wdata = dwd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    //    ir ia  dr dw dl da  dwd     ig dg en we ma  wd     lk irv drv rd
    add(0, 0,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00); // 0 idle
    add(1, 3,  0, 0, 0, 0, 8'h00,  1, 0, 1, 0, 3, 8'h00, 0, 0, 0, 8'h00); // 1 fetch addr 3
    add(0, 0,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h5A); // 2 fetch data
    add(1, 1,  0, 0, 0, 0, 8'h00,  1, 0, 1, 0, 1, 8'h00, 0, 0, 0, 8'h00); // 3 if addr 1
    add(0, 0,  1, 0, 0, 4, 8'h00,  0, 1, 1, 0, 4, 8'h00, 0, 1, 0, 8'h58); // 4 ds addr 4
    add(1, 5,  0, 0, 0, 0, 8'h00,  1, 0, 1, 0, 5, 8'h00, 0, 0, 1, 8'h5B); // 5 if addr 5
    add(0, 0,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h5C); // 6
    add(0, 0,  1, 1, 0, 7, 8'h33,  0, 1, 1, 1, 7, 8'h33, 0, 0, 0, 8'h00); // 7 store 0x33
    add(0, 0,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00); // 8 no rvalid
    add(0, 0,  1, 0, 0, 7, 8'h00,  0, 1, 1, 0, 7, 8'h00, 0, 0, 0, 8'h00); // 9 read back
    add(0, 0,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 8'h33); // 10
    add(1, 2,  1, 1, 0, 6, 8'h11,  0, 1, 1, 1, 6, 8'h11, 0, 0, 0, 8'h00); // 11 cnt 0
    add(1, 2,  1, 1, 0, 6, 8'h11,  0, 1, 1, 1, 6, 8'h11, 0, 0, 0, 8'h00); // 12 cnt 1
    add(1, 2,  1, 1, 0, 6, 8'h11,  0, 1, 1, 1, 6, 8'h11, 0, 0, 0, 8'h00); // 13 cnt 2
    add(1, 2,  1, 1, 0, 6, 8'h11,  1, 0, 1, 0, 2, 8'h00, 0, 0, 0, 8'h00); // 14 forced if
    add(1, 2,  1, 1, 0, 6, 8'h11,  0, 1, 1, 1, 6, 8'h11, 0, 1, 0, 8'h59); // 15 cnt back 0
    add(0, 0,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00); // 16
    add(1, 0,  1, 0, 1, 2, 8'h00,  0, 1, 1, 0, 2, 8'h00, 0, 0, 0, 8'h00); // 17 locked load
    add(1, 0,  1, 1, 0, 2, 8'h44,  0, 1, 1, 1, 2, 8'h44, 1, 0, 1, 8'h59); // 18 unlock store
    add(1, 0,  0, 0, 0, 0, 8'h00,  1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00); // 19 if granted
    add(0, 0,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h57); // 20
    add(1, 1,  1, 0, 1, 4, 8'h00,  0, 1, 1, 0, 4, 8'h00, 0, 0, 0, 8'h00); // 21 enter lock
    add(1, 1,  1, 0, 1, 4, 8'h00,  0, 1, 1, 0, 4, 8'h00, 1, 0, 1, 8'h5B); // 22 cnt 1->2
    add(1, 1,  1, 0, 1, 4, 8'h00,  0, 1, 1, 0, 4, 8'h00, 1, 0, 1, 8'h5B); // 23 cnt 2->3
    add(1, 1,  1, 0, 1, 4, 8'h00,  0, 1, 1, 0, 4, 8'h00, 1, 0, 1, 8'h5B); // 24 no force in lock
    add(1, 1,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 8'h5B); // 25 idle ds exits
    add(1, 1,  1, 0, 0, 4, 8'h00,  1, 0, 1, 0, 1, 8'h00, 0, 0, 0, 8'h00); // 26 forced if
    add(0, 0,  0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h58); // 27

    // Reset state
    #12;
    check("rst if_rvalid", 32'(bus.if_rvalid), 0);
    check("rst ds_rvalid", 32'(bus.ds_rvalid), 0);
    check("rst locked",    32'(bus.locked), 0);
    check("rst starve_cnt", 32'(dut.starve_cnt), 0);
    check("rst mem_en",    32'(bus.mem_en), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      drive(v.ir, v.ia, v.dr, v.dw, v.dl, v.da, v.dwd);
      #1;
      check($sformatf("v%0d if_gnt", i),    32'(bus.if_gnt),    32'(v.e_ig));
      check($sformatf("v%0d ds_gnt", i),    32'(bus.ds_gnt),    32'(v.e_dg));
      check($sformatf("v%0d mem_en", i),    32'(bus.mem_en),    32'(v.e_en));
      check($sformatf("v%0d mem_we", i),    32'(bus.mem_we),    32'(v.e_we));
      check($sformatf("v%0d mem_addr", i),  32'(bus.mem_addr),  32'(v.e_ma));
      check($sformatf("v%0d mem_wdata", i), 32'(bus.mem_wdata), 32'(v.e_wd));
      check($sformatf("v%0d locked", i),    32'(bus.locked),    32'(v.e_lk));
      check($sformatf("v%0d if_rvalid", i), 32'(bus.if_rvalid), 32'(v.e_irv));
      check($sformatf("v%0d ds_rvalid", i), 32'(bus.ds_rvalid), 32'(v.e_drv));
      if (v.e_irv || v.e_drv)
        check($sformatf("v%0d rdata", i),   32'(bus.rdata),     32'(v.e_rd));
    end

    // Locked ds read granted, then reset pulsed in the next cycle.
    @(negedge clk);
    drive(0, 0, 1, 0, 1, 4, 8'h00);
    #1;
    check("pre-rst ds_gnt", 32'(bus.ds_gnt), 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("in-rst ds_rvalid", 32'(bus.ds_rvalid), 0);
    check("in-rst locked",    32'(bus.locked), 0);
    check("in-rst starve_cnt", 32'(dut.starve_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3, 0, 0, 0, 0, 8'h00);
    #1;
    check("post-rst ds_rvalid", 32'(bus.ds_rvalid), 0);
    check("post-rst if_rvalid", 32'(bus.if_rvalid), 0);
    check("post-rst locked",    32'(bus.locked), 0);
    check("post-rst starve_cnt", 32'(dut.starve_cnt), 0);
    check("post-rst if_gnt",    32'(bus.if_gnt), 1);
    check("post-rst mem_addr",  32'(bus.mem_addr), 3);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    #1;
    check("post-rst fetch if_rvalid", 32'(bus.if_rvalid), 1);
    check("post-rst fetch ds_rvalid", 32'(bus.ds_rvalid), 0);
    check("post-rst fetch rdata",     32'(bus.rdata), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
